// File: rtl/jtag_pkg.sv
// Shared JTAG/DMI types: TAP state encoding, DMI opcodes and DTM instruction encodings.
package jtag_pkg;

    typedef enum logic [3:0] {
        TestLogicReset,
        RunTestIdle,
        SelectDrScan,
        CaptureDr,
        ShiftDr,
        Exit1Dr,
        PauseDr,
        Exit2Dr,
        UpdateDr,
        SelectIrScan,
        CaptureIr,
        ShiftIr,
        Exit1Ir,
        PauseIr,
        Exit2Ir,
        UpdateIr
    } jtag_state_t;

    typedef enum logic [1:0] {
        DmiNop   = 2'd0,
        DmiRead  = 2'd1,
        DmiWrite = 2'd2,
        DmiBusy  = 2'd3
    } dmi_op_t;

    typedef enum logic [1:0] {
        SelBypass,
        SelIdcode,
        SelDtmcs,
        SelDmi
    } dr_sel_t;

    localparam logic [31:0] IR_IDCODE = 32'h0000_0001;
    localparam logic [31:0] IR_DTMCS  = 32'h0000_0010;
    localparam logic [31:0] IR_DMI    = 32'h0000_0011;

    // BYPASS is all ones across whatever IR width the TAP is built with.
    function automatic logic [31:0] ir_bypass(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    endfunction

endpackage

// File: rtl/dtm_jtag_dmi_if.sv
// DMI request/response channel between the debug transport module and the debug module.
interface dtm_jtag_dmi_if #(
    parameter int unsigned ABITS = 7
);
    logic             dmi_req_valid;
    logic             dmi_req_ready;
    logic [ABITS-1:0] dmi_req_addr;
    logic [31:0]      dmi_req_data;
    logic [1:0]       dmi_req_op;
    logic             dmi_resp_valid;
    logic             dmi_resp_ready;
    logic [31:0]      dmi_resp_data;
    logic [1:0]       dmi_resp_op;

    modport master (
        output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
        input  dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_op
    );

    modport slave (
        input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_resp_ready,
        output dmi_req_ready, dmi_resp_valid, dmi_resp_data, dmi_resp_op
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller state machine; synchronous active-high reset to TestLogicReset.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic        tclk,
    input  logic        trst,
    input  logic        tms,
    output jtag_state_t state
);

    jtag_state_t state_q, state_d;

    always_ff @(posedge tclk) begin
        if (trst) begin
            state_q <= TestLogicReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TestLogicReset: state_d = tms ? TestLogicReset : RunTestIdle;
            RunTestIdle:    state_d = tms ? SelectDrScan   : RunTestIdle;
            SelectDrScan:   state_d = tms ? SelectIrScan   : CaptureDr;
            CaptureDr:      state_d = tms ? Exit1Dr        : ShiftDr;
            ShiftDr:        state_d = tms ? Exit1Dr        : ShiftDr;
            Exit1Dr:        state_d = tms ? UpdateDr       : PauseDr;
            PauseDr:        state_d = tms ? Exit2Dr        : PauseDr;
            Exit2Dr:        state_d = tms ? UpdateDr       : ShiftDr;
            UpdateDr:       state_d = tms ? SelectDrScan   : RunTestIdle;
            SelectIrScan:   state_d = tms ? TestLogicReset : CaptureIr;
            CaptureIr:      state_d = tms ? Exit1Ir        : ShiftIr;
            ShiftIr:        state_d = tms ? Exit1Ir        : ShiftIr;
            Exit1Ir:        state_d = tms ? UpdateIr       : PauseIr;
            PauseIr:        state_d = tms ? Exit2Ir        : PauseIr;
            Exit2Ir:        state_d = tms ? UpdateIr       : ShiftIr;
            UpdateIr:       state_d = tms ? SelectDrScan   : RunTestIdle;
            default:        state_d = TestLogicReset;
        endcase
    end

    always_comb begin
        state = state_q;
    end

endmodule

// File: rtl/dtm_jtag_dmi.sv
// RISC-V debug transport module: TAP, IR, IDCODE/BYPASS/DTMCS/DMI data registers and
// the valid/ready DMI request/response handshake, all in the tclk domain.
module dtm_jtag_dmi
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH     = 5,
    parameter logic [31:0] IDCODE_VALUE = 32'h1BEEF001,
    parameter int unsigned ABITS        = 7,
    parameter int unsigned DMI_IDLE     = 1
) (
    input  logic           tclk,
    input  logic           trst,
    input  logic           tms,
    input  logic           tdi,
    output logic           tdo,
    output logic           tdo_en,
    dtm_jtag_dmi_if.master dmi
);

    localparam int unsigned DrWidth = ABITS + 34;
    localparam logic [IR_WIDTH-1:0] IrIdcode = IR_WIDTH'(IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IrDtmcs  = IR_WIDTH'(IR_DTMCS);
    localparam logic [IR_WIDTH-1:0] IrDmi    = IR_WIDTH'(IR_DMI);
    localparam logic [IR_WIDTH-1:0] IrBypass = IR_WIDTH'(ir_bypass(IR_WIDTH));

    jtag_state_t state;

    logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DrWidth-1:0]  dr_sr_q, dr_sr_d;
    logic                tdo_q;
    logic                pending_q, pending_d;
    logic                req_valid_q, req_valid_d;
    logic                resp_ready_q, resp_ready_d;
    logic                discard_q, discard_d;
    logic [1:0]          sticky_q, sticky_d;
    logic [ABITS-1:0]    last_addr_q, last_addr_d;
    logic [31:0]         last_data_q, last_data_d;
    logic [ABITS-1:0]    req_addr_q, req_addr_d;
    logic [31:0]         req_data_q, req_data_d;
    dmi_op_t             req_op_q, req_op_d;

    dr_sel_t             dr_sel;
    logic                resp_fire, resp_take, accept;
    logic                pending_eff;
    logic [1:0]          sticky_eff;
    logic [31:0]         last_data_eff;
    dmi_op_t             upd_op;

    jtag_tap_fsm u_tap_fsm (
        .tclk  (tclk),
        .trst  (trst),
        .tms   (tms),
        .state (state)
    );

    always_comb begin
        case (ir_q)
            IrIdcode: dr_sel = SelIdcode;
            IrDtmcs:  dr_sel = SelDtmcs;
            IrDmi:    dr_sel = SelDmi;
            IrBypass: dr_sel = SelBypass;
            default:  dr_sel = SelBypass;
        endcase
    end

    // A response landing on the same edge as a capture is folded in first, so the capture
    // reports the freshly returned data and sticky status.
    always_comb begin
        accept        = req_valid_q & dmi.dmi_req_ready;
        resp_fire     = resp_ready_q & dmi.dmi_resp_valid;
        resp_take     = resp_fire & ~discard_q;
        pending_eff   = pending_q & ~resp_take;
        last_data_eff = resp_take ? dmi.dmi_resp_data : last_data_q;
        sticky_eff    = sticky_q;
        if (resp_take && sticky_q == 2'd0 && dmi.dmi_resp_op[1]) begin
            sticky_eff = dmi.dmi_resp_op;
        end
        upd_op = dmi_op_t'(dr_sr_q[1:0]);
    end

    always_comb begin
        ir_d         = ir_q;
        ir_sr_d      = ir_sr_q;
        dr_sr_d      = dr_sr_q;
        pending_d    = pending_eff;
        sticky_d     = sticky_eff;
        last_data_d  = last_data_eff;
        last_addr_d  = last_addr_q;
        req_valid_d  = req_valid_q;
        resp_ready_d = resp_ready_q;
        discard_d    = discard_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_op_d     = req_op_q;

        if (accept) begin
            req_valid_d  = 1'b0;
            resp_ready_d = 1'b1;
        end
        if (resp_fire) begin
            resp_ready_d = 1'b0;
            discard_d    = 1'b0;
        end

        case (state)
            TestLogicReset: ir_d = IrIdcode;
            CaptureIr:      ir_sr_d = IR_WIDTH'(2'b01);
            ShiftIr:        ir_sr_d = {tdi, ir_sr_q[IR_WIDTH-1:1]};
            UpdateIr:       ir_d = ir_sr_q;
            CaptureDr: begin
                case (dr_sel)
                    SelIdcode: dr_sr_d = DrWidth'(IDCODE_VALUE);
                    SelDtmcs:  dr_sr_d = DrWidth'({14'b0, 2'b00, 1'b0, 3'(DMI_IDLE), sticky_eff,
                                                   6'(ABITS), 4'd1});
                    SelDmi: begin
                        if (pending_eff) begin
                            dr_sr_d = {last_addr_q, last_data_eff, 2'b11};
                            if (sticky_eff == 2'd0) begin
                                sticky_d = 2'd3;
                            end
                        end else begin
                            dr_sr_d = {last_addr_q, last_data_eff, sticky_eff};
                        end
                    end
                    default:   dr_sr_d = '0;
                endcase
            end
            ShiftDr: begin
                case (dr_sel)
                    SelIdcode, SelDtmcs: dr_sr_d = DrWidth'({tdi, dr_sr_q[31:1]});
                    SelDmi:              dr_sr_d = {tdi, dr_sr_q[DrWidth-1:1]};
                    default:             dr_sr_d = DrWidth'(tdi);
                endcase
            end
            UpdateDr: begin
                if (dr_sel == SelDtmcs) begin
                    if (dr_sr_q[17]) begin
                        // Abandon: a response already owed by the DM is swallowed when it arrives.
                        sticky_d    = 2'd0;
                        pending_d   = 1'b0;
                        req_valid_d = 1'b0;
                        discard_d   = resp_ready_d;
                    end else if (dr_sr_q[16]) begin
                        sticky_d = 2'd0;
                    end
                end else if (dr_sel == SelDmi) begin
                    if ((upd_op == DmiRead || upd_op == DmiWrite) && sticky_eff == 2'd0 &&
                        !pending_eff) begin
                        req_addr_d  = dr_sr_q[DrWidth-1:34];
                        req_data_d  = dr_sr_q[33:2];
                        req_op_d    = upd_op;
                        last_addr_d = dr_sr_q[DrWidth-1:34];
                        pending_d   = 1'b1;
                        req_valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge tclk) begin
        if (trst) begin
            ir_q         <= IrIdcode;
            ir_sr_q      <= '0;
            dr_sr_q      <= '0;
            pending_q    <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            discard_q    <= 1'b0;
            sticky_q     <= 2'd0;
            last_addr_q  <= '0;
            last_data_q  <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_op_q     <= DmiNop;
        end else begin
            ir_q         <= ir_d;
            ir_sr_q      <= ir_sr_d;
            dr_sr_q      <= dr_sr_d;
            pending_q    <= pending_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            discard_q    <= discard_d;
            sticky_q     <= sticky_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_op_q     <= req_op_d;
        end
    end

    always_ff @(negedge tclk) begin
        if (trst) begin
            tdo_q <= 1'b0;
        end else if (state == ShiftIr) begin
            tdo_q <= ir_sr_q[0];
        end else if (state == ShiftDr) begin
            tdo_q <= dr_sr_q[0];
        end else begin
            tdo_q <= 1'b0;
        end
    end

    assign tdo    = tdo_q;
    assign tdo_en = (state == ShiftDr) || (state == ShiftIr);

    assign dmi.dmi_req_valid  = req_valid_q;
    assign dmi.dmi_req_addr   = req_addr_q;
    assign dmi.dmi_req_data   = req_data_q;
    assign dmi.dmi_req_op     = req_op_q;
    assign dmi.dmi_resp_ready = resp_ready_q;

endmodule

// File: tb/tb_dtm_jtag_dmi.sv
// Directed bench for dtm_jtag_dmi: table of IR/DR scans plus handshake corner sequences.
module tb_dtm_jtag_dmi;

    localparam int IrW = 5;
    localparam int DmiW = 41;

    logic tclk;
    logic trst;
    logic tms;
    logic tdi;
    logic tdo;
    logic tdo_en;

    int n_checks = 0;
    int n_err = 0;

    dtm_jtag_dmi_if #(.ABITS(7)) dmi ();

    dtm_jtag_dmi #(
        .IR_WIDTH     (5),
        .IDCODE_VALUE (32'h1BEEF001),
        .ABITS        (7),
        .DMI_IDLE     (1)
    ) dut (
        .tclk   (tclk),
        .trst   (trst),
        .tms    (tms),
        .tdi    (tdi),
        .tdo    (tdo),
        .tdo_en (tdo_en),
        .dmi    (dmi)
    );

    initial begin
        tclk = 1'b0;
        forever #5 tclk = ~tclk;
    end

    typedef struct {
        logic [4:0]  ir;
        int          w;
        logic [63:0] din;
        logic [63:0] dout;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample tdo/tdo_en for the current state, then apply tms/tdi for the next rising edge.
    task automatic step(input logic m, input logic d, output logic o, output logic oe);
        @(negedge tclk);
        #1;
        o   = tdo;
        oe  = tdo_en;
        tms = m;
        tdi = d;
        @(posedge tclk);
        #1;
    endtask

    task automatic idle(input int n);
        logic o, oe;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, o, oe);
    endtask

    task automatic scan_ir(input logic [4:0] v, output logic [4:0] vout);
        logic o, oe;
        vout = '0;
        step(1'b1, 1'b0, o, oe);
        step(1'b1, 1'b0, o, oe);
        step(1'b0, 1'b0, o, oe);
        step(1'b0, 1'b0, o, oe);
        for (int i = 0; i < IrW; i++) begin
            step(i == IrW - 1, v[i], o, oe);
            vout[i] = o;
        end
        step(1'b1, 1'b0, o, oe);
        step(1'b0, 1'b0, o, oe);
    endtask

    task automatic scan_dr(input int w, input logic [63:0] din, output logic [63:0] dout,
                           output int en_cnt);
        logic o, oe;
        dout   = '0;
        en_cnt = 0;
        step(1'b1, 1'b0, o, oe); en_cnt += int'(oe);
        step(1'b0, 1'b0, o, oe); en_cnt += int'(oe);
        step(1'b0, 1'b0, o, oe); en_cnt += int'(oe);
        for (int i = 0; i < w; i++) begin
            step(i == w - 1, din[i], o, oe);
            dout[i] = o;
            en_cnt += int'(oe);
        end
        step(1'b1, 1'b0, o, oe); en_cnt += int'(oe);
        step(1'b0, 1'b0, o, oe); en_cnt += int'(oe);
    endtask

    function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                             input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    initial begin
        logic [4:0]  iro;
        logic [63:0] dout;
        int          en;
        logic        o, oe;

        vecs[0] = '{ir: 5'h01, w: 32,   din: 64'h0,  dout: 64'h1BEEF001};
        vecs[1] = '{ir: 5'h10, w: 32,   din: 64'h0,  dout: 64'h00001071};
        vecs[2] = '{ir: 5'h1F, w: 8,    din: 64'hA5, dout: 64'h4A};
        vecs[3] = '{ir: 5'h05, w: 8,    din: 64'h3C, dout: 64'h78};
        vecs[4] = '{ir: 5'h11, w: DmiW, din: 64'h0,  dout: 64'h0};

        trst = 1'b1;
        tms  = 1'b1;
        tdi  = 1'b0;
        dmi.dmi_req_ready  = 1'b0;
        dmi.dmi_resp_valid = 1'b0;
        dmi.dmi_resp_data  = '0;
        dmi.dmi_resp_op    = 2'd0;
        repeat (2) @(posedge tclk);
        #1;
        trst = 1'b0;
        check("reset_tdo", 64'(tdo), 64'd0);
        check("reset_tdo_en", 64'(tdo_en), 64'd0);
        check("reset_req_valid", 64'(dmi.dmi_req_valid), 64'd0);
        check("reset_resp_ready", 64'(dmi.dmi_resp_ready), 64'd0);

        idle(1);
        scan_dr(32, 64'h0, dout, en);
        check("idcode_after_reset", dout, 64'h1BEEF001);
        check("idcode_tdo_en_cycles", 64'(en), 64'd32);

        for (int k = 0; k < 5; k++) begin
            scan_ir(vecs[k].ir, iro);
            check($sformatf("vec%0d_ir_capture", k), 64'(iro), 64'h1);
            scan_dr(vecs[k].w, vecs[k].din, dout, en);
            check($sformatf("vec%0d_dr_out", k), dout, vecs[k].dout);
            check($sformatf("vec%0d_tdo_en", k), 64'(en), 64'(vecs[k].w));
        end

        // Write with ready stalled for three cycles, then an ok response.
        scan_dr(DmiW, dmi_word(7'h10, 32'hDEADBEEF, 2'd2), dout, en);
        check("wr_capture_idle", dout, 64'h0);
        check("wr_valid", 64'(dmi.dmi_req_valid), 64'd1);
        check("wr_addr", 64'(dmi.dmi_req_addr), 64'h10);
        check("wr_data", 64'(dmi.dmi_req_data), 64'hDEADBEEF);
        check("wr_op", 64'(dmi.dmi_req_op), 64'd2);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check($sformatf("wr_hold_valid%0d", i), 64'(dmi.dmi_req_valid), 64'd1);
            check($sformatf("wr_hold_data%0d", i), 64'(dmi.dmi_req_data), 64'hDEADBEEF);
            check($sformatf("wr_hold_addr%0d", i), 64'(dmi.dmi_req_addr), 64'h10);
        end
        dmi.dmi_req_ready = 1'b1;
        idle(1);
        dmi.dmi_req_ready = 1'b0;
        check("wr_accept_valid", 64'(dmi.dmi_req_valid), 64'd0);
        check("wr_accept_resp_ready", 64'(dmi.dmi_resp_ready), 64'd1);
        dmi.dmi_resp_valid = 1'b1;
        dmi.dmi_resp_data  = 32'h12345678;
        dmi.dmi_resp_op    = 2'd0;
        idle(1);
        dmi.dmi_resp_valid = 1'b0;
        check("wr_resp_ready_drop", 64'(dmi.dmi_resp_ready), 64'd0);
        scan_dr(DmiW, 64'h0, dout, en);
        check("wr_result_capture", dout, dmi_word(7'h10, 32'h12345678, 2'd0));
        check("nop_no_request", 64'(dmi.dmi_req_valid), 64'd0);

        // Read left unanswered: busy capture, sticky blocks new requests.
        dmi.dmi_req_ready = 1'b1;
        scan_dr(DmiW, dmi_word(7'h05, 32'h0, 2'd1), dout, en);
        check("rd_valid", 64'(dmi.dmi_req_valid), 64'd1);
        idle(1);
        check("rd_resp_ready", 64'(dmi.dmi_resp_ready), 64'd1);
        scan_dr(DmiW, 64'h0, dout, en);
        check("busy_capture", dout, dmi_word(7'h05, 32'h12345678, 2'd3));
        scan_dr(DmiW, dmi_word(7'h01, 32'h1, 2'd2), dout, en);
        check("sticky_no_request", 64'(dmi.dmi_req_valid), 64'd0);
        scan_ir(5'h10, iro);
        scan_dr(32, 64'h0, dout, en);
        check("dtmcs_sticky3", dout, 64'h00001C71);
        scan_dr(32, 64'h1_0000, dout, en);
        scan_dr(32, 64'h0, dout, en);
        check("dtmcs_dmireset", dout, 64'h00001071);
        dmi.dmi_resp_valid = 1'b1;
        dmi.dmi_resp_data  = 32'hCAFEF00D;
        dmi.dmi_resp_op    = 2'd2;
        idle(1);
        dmi.dmi_resp_valid = 1'b0;
        check("rd_resp_ready_drop", 64'(dmi.dmi_resp_ready), 64'd0);
        scan_dr(32, 64'h1_0000, dout, en);
        check("dtmcs_failed", dout, 64'h00001871);
        scan_dr(32, 64'h0, dout, en);
        check("dtmcs_cleared", dout, 64'h00001071);
        scan_ir(5'h11, iro);
        scan_dr(DmiW, 64'h0, dout, en);
        check("failed_data_capture", dout, dmi_word(7'h05, 32'hCAFEF00D, 2'd0));

        // Hardreset while a response is owed: the late response is swallowed.
        scan_dr(DmiW, dmi_word(7'h22, 32'hAAAA5555, 2'd2), dout, en);
        idle(1);
        check("hr_accepted", 64'(dmi.dmi_resp_ready), 64'd1);
        scan_ir(5'h10, iro);
        scan_dr(32, 64'h2_0000, dout, en);
        check("hr_capture", dout, 64'h00001071);
        check("hr_resp_ready_held", 64'(dmi.dmi_resp_ready), 64'd1);
        dmi.dmi_resp_valid = 1'b1;
        dmi.dmi_resp_data  = 32'h0BADF00D;
        dmi.dmi_resp_op    = 2'd2;
        idle(1);
        dmi.dmi_resp_valid = 1'b0;
        check("hr_consumed", 64'(dmi.dmi_resp_ready), 64'd0);
        scan_dr(32, 64'h0, dout, en);
        check("hr_sticky_untouched", dout, 64'h00001071);
        scan_ir(5'h11, iro);
        scan_dr(DmiW, 64'h0, dout, en);
        check("hr_data_untouched", dout, dmi_word(7'h22, 32'hCAFEF00D, 2'd0));
        dmi.dmi_req_ready = 1'b0;

        // Five TMS=1 from SHIFT_DR reach TLR, which restores IDCODE.
        scan_ir(5'h1F, iro);
        step(1'b1, 1'b0, o, oe);
        step(1'b0, 1'b0, o, oe);
        step(1'b0, 1'b0, o, oe);
        step(1'b1, 1'b0, o, oe);
        check("shiftdr_tdo_en", 64'(oe), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, o, oe);
        step(1'b0, 1'b0, o, oe);
        scan_dr(32, 64'h0, dout, en);
        check("tlr_idcode", dout, 64'h1BEEF001);

        // trst mid-request clears the handshake; stray responses are ignored.
        scan_ir(5'h11, iro);
        scan_dr(DmiW, dmi_word(7'h03, 32'h7, 2'd2), dout, en);
        check("trst_pre_valid", 64'(dmi.dmi_req_valid), 64'd1);
        trst = 1'b1;
        idle(1);
        trst = 1'b0;
        check("trst_valid", 64'(dmi.dmi_req_valid), 64'd0);
        check("trst_resp_ready", 64'(dmi.dmi_resp_ready), 64'd0);
        dmi.dmi_resp_valid = 1'b1;
        dmi.dmi_resp_data  = 32'h55AA55AA;
        idle(1);
        check("stray_resp_ready", 64'(dmi.dmi_resp_ready), 64'd0);
        dmi.dmi_resp_valid = 1'b0;
        scan_ir(5'h11, iro);
        scan_dr(DmiW, 64'h0, dout, en);
        check("trst_dmi_cleared", dout, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
